// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 configuration path: ROM markers,
// sequencer state encoding and a saturating byte increment.
package ov7670_pkg;

    localparam logic [15:0] ROM_END   = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY = 16'hFFF0;
    localparam logic [7:0]  ADDR_LAST = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_DONE
    } cfg_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ov7670_cfg_seq.sv
// Walks the OV7670 register ROM after a start pulse, turning each entry into
// an SCCB write request, a fixed delay, or the end of the sequence.
module ov7670_cfg_seq
    import ov7670_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sccb_req,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_val,
    input  logic        sccb_ready,
    input  logic        sccb_done,
    output logic        busy,
    output logic        done,
    output logic [7:0]  wr_count
);

    localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [DW-1:0] DELAY_LOAD = DW'(DELAY_CYCLES - 1);

    cfg_state_t    state_reg;
    logic [DW-1:0] delay_cnt_reg;
    logic          advance;
    logic          at_last;

    // An entry is finished either when its write completes or its delay runs out.
    assign advance = ((state_reg == ST_WAIT_DONE) && sccb_done) ||
                     ((state_reg == ST_DELAY) && (delay_cnt_reg == '0));
    assign at_last = (rom_addr == ADDR_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            delay_cnt_reg <= '0;
            rom_addr      <= 8'd0;
            sccb_req      <= 1'b0;
            sccb_reg      <= 8'd0;
            sccb_val      <= 8'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            wr_count      <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg <= ST_FETCH;
                        rom_addr  <= 8'd0;
                        wr_count  <= 8'd0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_reg <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (rom_data == ROM_END) begin
                        state_reg <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (rom_data == ROM_DELAY) begin
                        state_reg     <= ST_DELAY;
                        delay_cnt_reg <= DELAY_LOAD;
                    end else begin
                        state_reg <= ST_SEND;
                        sccb_reg  <= rom_data[15:8];
                        sccb_val  <= rom_data[7:0];
                        sccb_req  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (sccb_ready) begin
                        sccb_req  <= 1'b0;
                        state_reg <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (sccb_done) begin
                        wr_count <= sat_inc8(wr_count);
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt_reg != '0) begin
                        delay_cnt_reg <= delay_cnt_reg - DW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            // Address 255 is the last ROM slot; the sequence never wraps.
            if (advance) begin
                if (at_last) begin
                    state_reg <= ST_DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    rom_addr  <= rom_addr + 8'd1;
                    state_reg <= ST_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// Bench for ov7670_cfg_seq: behavioural ROM, SCCB writer stub and a
// transaction-level model of the expected write stream and write count.
module tb_ov7670_cfg_seq;

    localparam int DLY = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_req;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_val;
    logic        sccb_ready = 1'b1;
    logic        sccb_done;
    logic        stub_done = 1'b0;
    logic        stray_done = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  wr_count;

    assign sccb_done = stub_done | stray_done;

    ov7670_cfg_seq #(.DELAY_CYCLES(DLY)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .sccb_req  (sccb_req),
        .sccb_reg  (sccb_reg),
        .sccb_val  (sccb_val),
        .sccb_ready(sccb_ready),
        .sccb_done (sccb_done),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    // Registered ROM, one cycle of read latency.
    logic [15:0] rom [256];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SCCB writer stub: optional back-pressure, done pulse done_lat cycles after accept.
    int bp_cycles = 0;
    int done_lat  = 3;
    int hold_cnt  = 0;
    int done_cnt  = 0;
    bit acc_pending = 1'b0;

    always @(negedge clk) begin
        stub_done = 1'b0;
        if (reset) begin
            hold_cnt    = 0;
            done_cnt    = 0;
            acc_pending = 1'b0;
            sccb_ready  = (bp_cycles == 0);
        end else begin
            if (acc_pending) done_cnt = done_lat;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) stub_done = 1'b1;
            end
            if (sccb_req) hold_cnt++;
            else hold_cnt = 0;
            sccb_ready  = (bp_cycles == 0) || (sccb_req && hold_cnt > bp_cycles);
            acc_pending = sccb_req && sccb_ready;
        end
    end

    // Model: the write stream is the ROM scanned up to the end marker with
    // delay markers dropped; the count is completed writes, capped at 255.
    logic [15:0] exp_q[$];
    int          acc_cyc[$];
    logic [15:0] acc_word[$];
    int          model_cnt = 0;
    bit          outstanding = 1'b0;
    int          req_len = 0;
    int          start_cyc = 0;
    int          done_cyc = -1;
    logic        req_q = 1'b0, busy_q = 1'b0, done_q = 1'b0;
    logic [7:0]  reg_q = 8'd0, val_q = 8'd0;

    task automatic build_expected();
        exp_q.delete();
        for (int a = 0; a < 256; a++) begin
            if (rom[a] == 16'hFFFF) break;
            if (rom[a] != 16'hFFF0) exp_q.push_back(rom[a]);
        end
    endtask

    always begin
        logic [31:0] exp_w;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            exp_q.delete();
            model_cnt   = 0;
            outstanding = 1'b0;
            req_len     = 0;
            req_q       = 1'b0;
            busy_q      = 1'b0;
            done_q      = 1'b0;
        end else begin
            if (start && !busy_q) begin
                build_expected();
                model_cnt   = 0;
                outstanding = 1'b0;
                acc_cyc.delete();
                acc_word.delete();
                start_cyc   = cyc;
                done_cyc    = -1;
            end
            if (req_q && sccb_ready) begin
                if (exp_q.size() > 0) exp_w = {16'h0, exp_q.pop_front()};
                else exp_w = 32'h1_0000;
                chk("write_order", {16'h0, reg_q, val_q}, exp_w);
                chk("req_hold_cycles", req_len, bp_cycles + 1);
                outstanding = 1'b1;
                acc_cyc.push_back(cyc);
                acc_word.push_back({reg_q, val_q});
                $display("write %0d reg=%02h val=%02h cycle=%0d", acc_word.size(), reg_q, val_q, cyc);
            end else if (outstanding && sccb_done) begin
                model_cnt   = (model_cnt < 255) ? model_cnt + 1 : 255;
                outstanding = 1'b0;
            end
            if (done && !done_q) done_cyc = cyc;
            chk("wr_count", {24'h0, wr_count}, model_cnt);
            if (sccb_req) begin
                exp_w = (exp_q.size() > 0) ? {16'h0, exp_q[0]} : 32'h1_0000;
                chk("req_payload", {16'h0, sccb_reg, sccb_val}, exp_w);
                chk("busy_during_req", {31'h0, busy}, 1);
            end
            req_len = sccb_req ? req_len + 1 : 0;
            req_q   = sccb_req;
            reg_q   = sccb_reg;
            val_q   = sccb_val;
            busy_q  = busy;
            done_q  = done;
        end
    end

    task automatic load_camera_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1214;
        for (int i = 3; i < 74; i++) rom[i] = {8'(8'h13 + i), 8'(i * 3)};
        rom[74] = 16'h6907;
    endtask

    task automatic load_full_rom();
        for (int i = 0; i < 256; i++) rom[i] = {8'(i), 8'(i + 1)};
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stray();
        @(negedge clk); stray_done = 1'b1;
        @(negedge clk); stray_done = 1'b0;
    endtask

    task automatic wait_run_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("run_finished", {31'h0, done}, 1);
    endtask

    task automatic wait_accepts(input int count, input int budget);
        int n = 0;
        while (acc_cyc.size() < count && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("accepts_reached", (acc_cyc.size() >= count) ? 1 : 0, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rom_addr"}, {24'h0, rom_addr}, 0);
        chk({tag, "_sccb_req"}, {31'h0, sccb_req}, 0);
        chk({tag, "_sccb_reg"}, {24'h0, sccb_reg}, 0);
        chk({tag, "_sccb_val"}, {24'h0, sccb_val}, 0);
        chk({tag, "_busy"}, {31'h0, busy}, 0);
        chk({tag, "_done"}, {31'h0, done}, 0);
        chk({tag, "_wr_count"}, {24'h0, wr_count}, 0);
    endtask

    task automatic check_full_run(input string tag);
        int n = acc_word.size();
        chk({tag, "_writes"}, n, 74);
        chk({tag, "_first"}, (n > 0) ? {16'h0, acc_word[0]} : 32'h0, 32'h1280);
        chk({tag, "_second"}, (n > 1) ? {16'h0, acc_word[1]} : 32'h0, 32'h1214);
        chk({tag, "_last"}, (n > 0) ? {16'h0, acc_word[n-1]} : 32'h0, 32'h6907);
        chk({tag, "_wr_count"}, {24'h0, wr_count}, 74);
        chk({tag, "_end_addr"}, {24'h0, rom_addr}, 75);
        chk({tag, "_busy"}, {31'h0, busy}, 0);
        chk({tag, "_done"}, {31'h0, done}, 1);
        if (bp_cycles == 0 && n > 2) begin
            chk({tag, "_start_latency"}, acc_cyc[0] - start_cyc, 3);
            chk({tag, "_delay_gap"}, acc_cyc[1] - acc_cyc[0], 6 + DLY + 2);
            chk({tag, "_write_gap"}, acc_cyc[2] - acc_cyc[1], 6);
            chk({tag, "_done_latency"}, done_cyc - acc_cyc[n-1], 5);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        load_camera_rom();
        #1;
        check_zero("reset_async");
        repeat (3) @(negedge clk);
        check_zero("reset_held");
        reset = 1'b0;

        // Stray done pulse in IDLE must not count.
        pulse_stray();
        repeat (2) @(negedge clk);
        chk("idle_stray_wr_count", {24'h0, wr_count}, 0);
        chk("idle_stray_done", {31'h0, done}, 0);

        // Full run, writer always ready.
        pulse_start();
        wait_run_done(2000);
        check_full_run("run1");

        // Stray done in DONE, then restart with ignored mid-run starts.
        pulse_stray();
        repeat (2) @(negedge clk);
        chk("done_stray_wr_count", {24'h0, wr_count}, 74);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        chk("restart_done_drop", {31'h0, done}, 0);
        chk("restart_busy", {31'h0, busy}, 1);
        @(negedge clk); start = 1'b0;
        wait_accepts(1, 100);
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("delay_start_addr", {24'h0, rom_addr}, 1);
        chk("delay_start_wr_count", {24'h0, wr_count}, 1);
        chk("delay_start_busy", {31'h0, busy}, 1);
        wait_accepts(5, 200);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("wait_start_addr", {24'h0, rom_addr}, 5);
        chk("wait_start_wr_count", {24'h0, wr_count}, 4);
        wait_run_done(2000);
        check_full_run("run2");

        // Back-pressure: writer holds ready low for 10 cycles per request.
        bp_cycles = 10;
        pulse_start();
        wait_run_done(4000);
        check_full_run("bp");
        bp_cycles = 0;

        // Reset mid-delay.
        pulse_start();
        wait_accepts(1, 100);
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("reset_mid_delay");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset while a request is pending.
        pulse_start();
        wait_accepts(3, 200);
        begin
            int k = 0;
            while (!sccb_req && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        chk("req_seen_before_reset", {31'h0, sccb_req}, 1);
        #2 reset = 1'b1;
        #1 check_zero("reset_mid_write");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        pulse_start();
        wait_run_done(2000);
        check_full_run("after_reset");

        // 256 plain entries: no wrap at address 255, count saturates.
        load_full_rom();
        pulse_start();
        wait_run_done(3000);
        chk("full_writes", acc_word.size(), 256);
        chk("full_first", (acc_word.size() > 0) ? {16'h0, acc_word[0]} : 32'h0, 32'h0001);
        chk("full_last", (acc_word.size() > 0) ? {16'h0, acc_word[acc_word.size()-1]} : 32'h0, 32'hFF00);
        chk("full_wr_count", {24'h0, wr_count}, 255);
        chk("full_end_addr", {24'h0, rom_addr}, 255);
        chk("full_done", {31'h0, done}, 1);
        chk("full_busy", {31'h0, busy}, 0);
        repeat (3) @(negedge clk);
        chk("full_done_held", {31'h0, done}, 1);
        chk("full_addr_held", {24'h0, rom_addr}, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
